// File: rtl/imem_prog_loader_pkg.sv
// Shared definitions for the instruction-memory program loader: FSM state
// encoding and parameter defaults.
package imem_prog_loader_pkg;

    localparam int unsigned DEF_MEM_DEPTH   = 4096;
    localparam logic [7:0]  DEF_SYNC_BYTE   = 8'hA5;
    localparam int unsigned DEF_GAP_TIMEOUT = 100000;

    typedef enum logic [3:0] {
        S_IDLE,
        S_ADDR_H,
        S_ADDR_L,
        S_CNT_H,
        S_CNT_L,
        S_DATA_H,
        S_DATA_L,
        S_CSUM,
        S_FINISH
    } loader_state_e;

endpackage

// File: rtl/imem_prog_loader_gap_timer.sv
// Inter-byte gap timer: counts idle cycles while enabled, restarts on clear,
// and flags expiry once the count reaches TIMEOUT.
module loader_gap_timer #(
    parameter int unsigned TIMEOUT = 100000
) (
    input  logic clk,
    input  logic reset,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expire
);

    localparam int unsigned CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] r_cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt <= '0;
        end else if (!i_enable || i_clear) begin
            r_cnt <= '0;
        end else if (r_cnt != CW'(TIMEOUT)) begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

    assign o_expire = i_enable && (r_cnt == CW'(TIMEOUT));

endmodule

// File: rtl/imem_prog_loader.sv
// Program-image loader: unpacks a UART byte frame into 16-bit instruction writes.
// Define IMEM_LOADER_CHECKSUM_EN to require a trailing XOR checksum byte.
module imem_prog_loader
    import imem_prog_loader_pkg::*;
#(
    parameter int unsigned MEM_DEPTH   = DEF_MEM_DEPTH,
    parameter logic [7:0]  SYNC_BYTE   = DEF_SYNC_BYTE,
    parameter int unsigned GAP_TIMEOUT = DEF_GAP_TIMEOUT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        wr_en,
    output logic [15:0] wr_addr,
    output logic [15:0] wr_data,
    output logic        load_busy,
    output logic        load_done,
    output logic        load_err,
    output logic [15:0] boot_pc
);

`ifdef IMEM_LOADER_CHECKSUM_EN
    localparam loader_state_e END_STATE = S_CSUM;
`else
    localparam loader_state_e END_STATE = S_FINISH;
`endif

    loader_state_e r_state, w_state_nxt;
    logic [15:0] r_start, w_start_nxt;
    logic [15:0] r_addr, w_addr_nxt;
    logic [15:0] r_rem, w_rem_nxt;
    logic [7:0]  r_hi, w_hi_nxt;
    logic        r_wr_en, w_wr_en_nxt;
    logic [15:0] r_wr_addr, w_wr_addr_nxt;
    logic [15:0] r_wr_data, w_wr_data_nxt;
    logic        r_busy, w_busy_nxt;
    logic        r_done, w_done_nxt;
    logic        r_err, w_err_nxt;
    logic [15:0] r_boot_pc, w_boot_nxt;
    logic [15:0] w_cnt;
    logic        w_fits;
    logic        w_expire;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0]  r_csum, w_csum_nxt;
`endif

    loader_gap_timer #(
        .TIMEOUT (GAP_TIMEOUT)
    ) u_gap_timer (
        .clk      (clk),
        .reset    (reset),
        .i_clear  (rx_valid),
        .i_enable (r_state != S_IDLE),
        .o_expire (w_expire)
    );

    // 17-bit sum so a start near 0xFFFF cannot wrap into range.
    assign w_cnt  = {r_rem[15:8], rx_data};
    assign w_fits = ({1'b0, r_start} + {1'b0, w_cnt}) <= 17'(MEM_DEPTH);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= S_IDLE;
            r_start   <= '0;
            r_addr    <= '0;
            r_rem     <= '0;
            r_hi      <= '0;
            r_wr_en   <= 1'b0;
            r_wr_addr <= '0;
            r_wr_data <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
            r_boot_pc <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            r_csum    <= '0;
`endif
        end else begin
            r_state   <= w_state_nxt;
            r_start   <= w_start_nxt;
            r_addr    <= w_addr_nxt;
            r_rem     <= w_rem_nxt;
            r_hi      <= w_hi_nxt;
            r_wr_en   <= w_wr_en_nxt;
            r_wr_addr <= w_wr_addr_nxt;
            r_wr_data <= w_wr_data_nxt;
            r_busy    <= w_busy_nxt;
            r_done    <= w_done_nxt;
            r_err     <= w_err_nxt;
            r_boot_pc <= w_boot_nxt;
`ifdef IMEM_LOADER_CHECKSUM_EN
            r_csum    <= w_csum_nxt;
`endif
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_start_nxt   = r_start;
        w_addr_nxt    = r_addr;
        w_rem_nxt     = r_rem;
        w_hi_nxt      = r_hi;
        w_wr_en_nxt   = 1'b0;
        w_wr_addr_nxt = r_wr_addr;
        w_wr_data_nxt = r_wr_data;
        w_busy_nxt    = r_busy;
        w_done_nxt    = 1'b0;
        w_err_nxt     = 1'b0;
        w_boot_nxt    = r_boot_pc;
`ifdef IMEM_LOADER_CHECKSUM_EN
        w_csum_nxt    = r_csum;
        if (rx_valid && (r_state inside {S_ADDR_H, S_ADDR_L, S_CNT_H, S_CNT_L, S_DATA_H, S_DATA_L}))
            w_csum_nxt = r_csum ^ rx_data;
`endif
        // Timeout wins over a byte arriving in the same cycle.
        if (w_expire) begin
            w_state_nxt = S_IDLE;
            w_busy_nxt  = 1'b0;
            w_err_nxt   = 1'b1;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (rx_valid && rx_data == SYNC_BYTE) begin
                        w_state_nxt = S_ADDR_H;
                        w_busy_nxt  = 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
                        w_csum_nxt  = '0;
`endif
                    end
                end
                S_ADDR_H: if (rx_valid) begin
                    w_start_nxt[15:8] = rx_data;
                    w_state_nxt       = S_ADDR_L;
                end
                S_ADDR_L: if (rx_valid) begin
                    w_start_nxt[7:0] = rx_data;
                    w_state_nxt      = S_CNT_H;
                end
                S_CNT_H: if (rx_valid) begin
                    w_rem_nxt[15:8] = rx_data;
                    w_state_nxt     = S_CNT_L;
                end
                S_CNT_L: if (rx_valid) begin
                    if (!w_fits) begin
                        w_state_nxt = S_IDLE;
                        w_busy_nxt  = 1'b0;
                        w_err_nxt   = 1'b1;
                    end else begin
                        w_rem_nxt   = w_cnt;
                        w_addr_nxt  = r_start;
                        w_state_nxt = (w_cnt == 16'd0) ? END_STATE : S_DATA_H;
                    end
                end
                S_DATA_H: if (rx_valid) begin
                    w_hi_nxt    = rx_data;
                    w_state_nxt = S_DATA_L;
                end
                S_DATA_L: if (rx_valid) begin
                    w_wr_en_nxt   = 1'b1;
                    w_wr_addr_nxt = r_addr;
                    w_wr_data_nxt = {r_hi, rx_data};
                    w_addr_nxt    = r_addr + 16'd1;
                    w_rem_nxt     = r_rem - 16'd1;
                    w_state_nxt   = (r_rem == 16'd1) ? END_STATE : S_DATA_H;
                end
`ifdef IMEM_LOADER_CHECKSUM_EN
                S_CSUM: if (rx_valid) begin
                    w_state_nxt = S_IDLE;
                    w_busy_nxt  = 1'b0;
                    if (rx_data == r_csum) begin
                        w_done_nxt = 1'b1;
                        w_boot_nxt = r_start;
                    end else begin
                        w_err_nxt  = 1'b1;
                    end
                end
`endif
                S_FINISH: begin
                    w_state_nxt = S_IDLE;
                    w_busy_nxt  = 1'b0;
                    w_done_nxt  = 1'b1;
                    w_boot_nxt  = r_start;
                end
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    assign wr_en     = r_wr_en;
    assign wr_addr   = r_wr_addr;
    assign wr_data   = r_wr_data;
    assign load_busy = r_busy;
    assign load_done = r_done;
    assign load_err  = r_err;
    assign boot_pc   = r_boot_pc;

endmodule

// File: tb/tb_imem_prog_loader.sv
// Self-checking bench for imem_prog_loader: frame table plus hand-written
// timeout / checksum / mid-frame reset sequences, with a write scoreboard.
module tb_imem_prog_loader;

    localparam int unsigned TB_GAP = 64;

    typedef struct {
        int unsigned sidx;
        int unsigned n;
        logic [95:0] b;
        bit          c;
        bit          bad;
        bit          ok;
        logic [15:0] boot;
        int unsigned nwr;
        logic [47:0] wa;
        logic [47:0] wd;
        int unsigned lg;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [7:0]  rx_data = '0;
    logic        rx_valid = 1'b0;
    logic        wr_en;
    logic [15:0] wr_addr;
    logic [15:0] wr_data;
    logic        load_busy;
    logic        load_done;
    logic        load_err;
    logic [15:0] boot_pc;

    int unsigned checks = 0;
    int unsigned failures = 0;
    int unsigned done_seen = 0;
    int unsigned err_seen = 0;
    logic [15:0] model_boot = '0;
    logic [31:0] exp_q[$];
    vec_t        vecs[10];
    vec_t        hv;

    imem_prog_loader #(
        .GAP_TIMEOUT (TB_GAP)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .load_busy (load_busy),
        .load_done (load_done),
        .load_err  (load_err),
        .boot_pc   (boot_pc)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        logic [31:0] e;
        @(negedge clk);
        if (wr_en === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_wr: got addr=%0h data=%0h expected no write", wr_addr, wr_data);
            end else begin
                e = exp_q.pop_front();
                check("wr_addr", {16'h0, wr_addr}, {16'h0, e[31:16]});
                check("wr_data", {16'h0, wr_data}, {16'h0, e[15:0]});
            end
        end
        if (load_done === 1'b1 && load_err === 1'b1) begin
            checks++;
            failures++;
            $display("FAIL done_err_overlap: got both 1 expected at most one");
        end
        if (load_done === 1'b1) done_seen++;
        if (load_err === 1'b1) err_seen++;
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0;
    endtask

    task automatic wait_outcome(input int unsigned d0, input int unsigned e0);
        for (int t = 0; t < 20 && done_seen == d0 && err_seen == e0; t++) tick();
        repeat (2) tick();
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        int unsigned d0;
        int unsigned e0;
        logic [7:0]  x;
        logic [7:0]  b;
        bit          ok;
        d0 = done_seen;
        e0 = err_seen;
        x  = '0;
        ok = v.ok;
        for (int unsigned k = 0; k < v.nwr; k++)
            exp_q.push_back({v.wa[(v.nwr-1-k)*16 +: 16], v.wd[(v.nwr-1-k)*16 +: 16]});
        for (int unsigned k = 0; k < v.n; k++) begin
            b = v.b[(v.n-1-k)*8 +: 8];
            if (k > v.sidx) x = x ^ b;
            send_byte(b);
            if (k == v.sidx) check({tag, "_busy_after_sync"}, {31'h0, load_busy}, 32'h1);
            if (v.lg != 0 && k + 1 == v.lg) repeat (TB_GAP - 8) tick();
            else repeat ($urandom_range(0, 2)) tick();
        end
`ifdef IMEM_LOADER_CHECKSUM_EN
        if (v.c) begin
            send_byte(v.bad ? (x ^ 8'hFF) : x);
            if (v.bad) ok = 1'b0;
        end
`endif
        wait_outcome(d0, e0);
        if (ok) model_boot = v.boot;
        check({tag, "_done"}, 32'(done_seen - d0), {31'h0, ok});
        check({tag, "_err"}, 32'(err_seen - e0), {31'h0, !ok});
        check({tag, "_boot_pc"}, {16'h0, boot_pc}, {16'h0, model_boot});
        check({tag, "_busy_end"}, {31'h0, load_busy}, 32'h0);
        check({tag, "_writes_left"}, 32'(exp_q.size()), 32'h0);
        exp_q.delete();
        repeat (3) tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned d0;
        int unsigned e0;
        int unsigned t;

        vecs[0] = '{sidx:0, n:9,  b:96'hA5_00_64_00_02_0D_00_0D_11, c:1, bad:0, ok:1, boot:16'h0064,
                    nwr:2, wa:48'h0064_0065, wd:48'h0D00_0D11, lg:0};
        vecs[1] = '{sidx:0, n:5,  b:96'hA5_0F_FF_00_02, c:0, bad:0, ok:0, boot:16'h0000,
                    nwr:0, wa:48'h0, wd:48'h0, lg:0};
        vecs[2] = '{sidx:2, n:9,  b:96'h3C_11_A5_00_C8_00_01_10_F0, c:1, bad:0, ok:1, boot:16'h00C8,
                    nwr:1, wa:48'h00C8, wd:48'h10F0, lg:0};
        vecs[3] = '{sidx:0, n:7,  b:96'hA5_0F_FF_00_01_AB_CD, c:1, bad:0, ok:1, boot:16'h0FFF,
                    nwr:1, wa:48'h0FFF, wd:48'hABCD, lg:0};
        vecs[4] = '{sidx:0, n:5,  b:96'hA5_00_10_00_00, c:1, bad:0, ok:1, boot:16'h0010,
                    nwr:0, wa:48'h0, wd:48'h0, lg:0};
        vecs[5] = '{sidx:0, n:5,  b:96'hA5_10_00_00_01, c:0, bad:0, ok:0, boot:16'h0000,
                    nwr:0, wa:48'h0, wd:48'h0, lg:0};
        vecs[6] = '{sidx:0, n:11, b:96'hA5_00_00_00_03_01_02_03_04_05_06, c:1, bad:0, ok:1, boot:16'h0000,
                    nwr:3, wa:48'h0000_0001_0002, wd:48'h0102_0304_0506, lg:0};
        vecs[7] = '{sidx:1, n:8,  b:96'h5A_A5_00_05_00_01_A5_A5, c:1, bad:0, ok:1, boot:16'h0005,
                    nwr:1, wa:48'h0005, wd:48'hA5A5, lg:0};
        vecs[8] = '{sidx:0, n:7,  b:96'hA5_00_30_00_01_12_34, c:1, bad:1, ok:1, boot:16'h0030,
                    nwr:1, wa:48'h0030, wd:48'h1234, lg:0};
        vecs[9] = '{sidx:0, n:5,  b:96'hA5_FF_FF_00_02, c:0, bad:0, ok:0, boot:16'h0000,
                    nwr:0, wa:48'h0, wd:48'h0, lg:0};

        repeat (3) @(negedge clk);
        check("rst_wr_en", {31'h0, wr_en}, 32'h0);
        check("rst_wr_addr", {16'h0, wr_addr}, 32'h0);
        check("rst_wr_data", {16'h0, wr_data}, 32'h0);
        check("rst_busy", {31'h0, load_busy}, 32'h0);
        check("rst_done_err", {30'h0, load_done, load_err}, 32'h0);
        check("rst_boot_pc", {16'h0, boot_pc}, 32'h0);
        reset = 1'b1;
        repeat (2) tick();

        for (int i = 0; i < 10; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

        // Long but legal gap before the final data byte.
        hv = '{sidx:0, n:7, b:96'hA5_00_40_00_01_AB_CD, c:1, bad:0, ok:1, boot:16'h0040,
               nwr:1, wa:48'h0040, wd:48'hABCD, lg:6};
        run_vec(hv, "slowgap");

        d0 = done_seen;
        e0 = err_seen;
        send_byte(8'hA5); send_byte(8'h00); send_byte(8'h64);
        send_byte(8'h00); send_byte(8'h01); send_byte(8'h0D);
        check("to_busy_before", {31'h0, load_busy}, 32'h1);
        t = 0;
        while (err_seen == e0 && t < TB_GAP + 10) begin
            tick();
            t++;
        end
        check("to_latency_ok", {31'h0, (t >= TB_GAP - 1) && (t <= TB_GAP + 2)}, 32'h1);
        repeat (2) tick();
        check("to_err", 32'(err_seen - e0), 32'h1);
        check("to_done", 32'(done_seen - d0), 32'h0);
        check("to_busy_after", {31'h0, load_busy}, 32'h0);
        check("to_boot_pc", {16'h0, boot_pc}, {16'h0, model_boot});
        repeat (3) tick();

`ifdef IMEM_LOADER_CHECKSUM_EN
        hv = '{sidx:0, n:8, b:96'hA5_00_64_00_01_0D_00_68, c:0, bad:0, ok:1, boot:16'h0064,
               nwr:1, wa:48'h0064, wd:48'h0D00, lg:0};
        run_vec(hv, "csum_ok");
        hv = '{sidx:0, n:8, b:96'hA5_00_70_00_01_0D_00_00, c:0, bad:0, ok:0, boot:16'h0070,
               nwr:1, wa:48'h0070, wd:48'h0D00, lg:0};
        run_vec(hv, "csum_bad");
`endif

        exp_q.push_back({16'h0064, 16'h0D00});
        send_byte(8'hA5); send_byte(8'h00); send_byte(8'h64); send_byte(8'h00);
        send_byte(8'h02); send_byte(8'h0D); send_byte(8'h00);
        check("mr_first_word", 32'(exp_q.size()), 32'h0);
        d0 = done_seen;
        e0 = err_seen;
        #2 reset = 1'b0;
        #1;
        check("mr_wr_en", {31'h0, wr_en}, 32'h0);
        check("mr_busy", {31'h0, load_busy}, 32'h0);
        check("mr_boot_pc", {16'h0, boot_pc}, 32'h0);
        check("mr_wr_addr_data", {wr_addr, wr_data}, 32'h0);
        model_boot = '0;
        repeat (2) tick();
        reset = 1'b1;
        repeat (3) tick();
        check("mr_no_pulse", 32'(done_seen - d0 + err_seen - e0), 32'h0);
        run_vec(vecs[0], "mr_reload");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
